// File: rtl/irq_scheduler_pkg.sv
// Shared constants and types for the three-bus interrupt scheduler.
// Bus encodings are one-hot so the grant can drive bus selects directly.
package irq_scheduler_pkg;

  localparam int unsigned NBUS   = 3;
  localparam int unsigned BUS_W  = 3;
  localparam int unsigned CHAN_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [BUS_W-1:0] BUS_A = 3'b001;
  localparam logic [BUS_W-1:0] BUS_B = 3'b010;
  localparam logic [BUS_W-1:0] BUS_C = 3'b100;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  function automatic logic [BUS_W-1:0] bus_onehot(input int unsigned b);
    case (b)
      0:       return BUS_A;
      1:       return BUS_B;
      default: return BUS_C;
    endcase
  endfunction

endpackage

// File: rtl/irq_prio_resolver.sv
// Fixed-priority resolver: bus A over B over C, lowest channel first.
// Eligible bits are packed {C, B, A}, channel-major within each bus.
module irq_prio_resolver
  import irq_scheduler_pkg::*;
#(
  parameter int unsigned NCH = 9
) (
  input  logic [NBUS*NCH-1:0] elig,
  output logic                found,
  output logic [BUS_W-1:0]    bus,
  output logic [CHAN_W-1:0]   chan
);

  always_comb begin
    found = 1'b0;
    bus   = '0;
    chan  = '0;
    for (int unsigned b = 0; b < NBUS; b++) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (!found && elig[b*NCH + c]) begin
          found = 1'b1;
          bus   = bus_onehot(b);
          chan  = CHAN_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: latches requests from three buses into a pending
// register and presents one grant at a time until ack or timeout.
module irq_scheduler
  import irq_scheduler_pkg::*;
#(
  parameter int unsigned NCH     = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic [NCH-1:0]    req_a,
  input  logic [NCH-1:0]    req_b,
  input  logic [NCH-1:0]    req_c,
  input  logic [NCH-1:0]    en,
  input  logic              ack,
  input  logic              err_clr,
  output logic              irq_valid,
  output logic [BUS_W-1:0]  irq_bus,
  output logic [CHAN_W-1:0] irq_chan,
  output logic              err_timeout
);

  localparam int unsigned      NREQ     = NBUS * NCH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state;
  logic [NREQ-1:0]     pend;
  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     clr_mask;
  logic [CNT_W-1:0]    cnt;
  logic                win_found;
  logic [BUS_W-1:0]    win_bus;
  logic [CHAN_W-1:0]   win_chan;
  logic                ack_ret;
  logic                tmo_ret;
  logic                retire;

  irq_prio_resolver #(
    .NCH (NCH)
  ) u_resolver (
    .elig  (elig),
    .found (win_found),
    .bus   (win_bus),
    .chan  (win_chan)
  );

  // The frozen grant outputs double as the record of which pend bit to retire.
  always_comb begin
    elig     = pend & {en, en, en};
    ack_ret  = (state == WAIT_ACK) && ack;
    tmo_ret  = (state == WAIT_ACK) && !ack && (cnt == CNT_LAST);
    retire   = ack_ret || tmo_ret;
    clr_mask = '0;
    for (int unsigned b = 0; b < NBUS; b++) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        clr_mask[b*NCH + c] = retire && irq_bus[b] && (irq_chan == CHAN_W'(c));
      end
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state       <= IDLE;
      pend        <= '0;
      cnt         <= '0;
      irq_valid   <= 1'b0;
      irq_bus     <= '0;
      irq_chan    <= '0;
      err_timeout <= 1'b0;
    end else begin
      // A request arriving with its own retirement keeps the bit set.
      pend <= (pend & ~clr_mask) | {req_c, req_b, req_a};

      if (tmo_ret) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= WAIT_ACK;
            irq_valid <= 1'b1;
            irq_bus   <= win_bus;
            irq_chan  <= win_chan;
            cnt       <= '0;
          end
        end
        WAIT_ACK: begin
          if (retire) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_scheduler.sv
// Bench for irq_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a queue-free behavioural model.
module tb_irq_scheduler;

  localparam int unsigned NCH     = 9;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned NREQ    = 3 * NCH;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] req_a = '0;
  logic [NCH-1:0] req_b = '0;
  logic [NCH-1:0] req_c = '0;
  logic [NCH-1:0] en = '1;
  logic           ack = 1'b0;
  logic           err_clr = 1'b0;
  logic           irq_valid;
  logic [2:0]     irq_bus;
  logic [3:0]     irq_chan;
  logic           err_timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Reference model state
  bit [NREQ-1:0] m_pend;
  bit            m_busy;
  int unsigned   m_g;
  int unsigned   m_wait;
  bit            m_err;
  logic [2:0]    m_bus;
  logic [3:0]    m_chan;

  always #5 clk = ~clk;

  irq_scheduler #(
    .NCH     (NCH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_c          (req_c),
    .en             (en),
    .ack            (ack),
    .err_clr        (err_clr),
    .irq_valid      (irq_valid),
    .irq_bus        (irq_bus),
    .irq_chan       (irq_chan),
    .err_timeout    (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit [NREQ-1:0] reqv;
    bit            ret;
    bit            tmo;
    int            win;
    reqv = {req_c, req_b, req_a};
    ret  = 1'b0;
    tmo  = 1'b0;
    win  = -1;
    if (rst) begin
      m_pend = '0;
      m_busy = 1'b0;
      m_wait = 0;
      m_err  = 1'b0;
      m_bus  = '0;
      m_chan = '0;
    end else begin
      if (!m_busy) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          if (win < 0 && m_pend[k] && en[k % NCH]) win = k;
        end
      end else begin
        if (ack) ret = 1'b1;
        else if (m_wait == TIMEOUT - 1) begin
          ret = 1'b1;
          tmo = 1'b1;
        end else m_wait++;
      end
      if (ret) m_pend[m_g] = 1'b0;
      m_pend = m_pend | reqv;
      if (tmo) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (ret) m_busy = 1'b0;
      else if (win >= 0) begin
        m_busy = 1'b1;
        m_g    = win;
        m_wait = 0;
        m_bus  = 3'(1 << (win / NCH));
        m_chan = 4'(win % NCH);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, "_valid"}, 32'(irq_valid), 32'(m_busy));
    check({tag, "_bus"}, 32'(irq_bus), 32'(m_bus));
    check({tag, "_chan"}, 32'(irq_chan), 32'(m_chan));
    check({tag, "_err"}, 32'(err_timeout), 32'(m_err));
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick(tag);
    ack = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick("rst0");
    tick("rst1");
    rst = 1'b0;
    check("rst_valid", 32'(irq_valid), 32'd0);
    check("rst_bus", 32'(irq_bus), 32'd0);
    check("rst_chan", 32'(irq_chan), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);

    // Single request latency and ack
    req_a = 9'h008;
    tick("s1_req");
    req_a = '0;
    check("s1_nograntyet", 32'(irq_valid), 32'd0);
    tick("s1_grant");
    check("s1_valid", 32'(irq_valid), 32'd1);
    check("s1_bus", 32'(irq_bus), 32'h1);
    check("s1_chan", 32'(irq_chan), 32'd3);
    do_ack("s1_ack");
    check("s1_released", 32'(irq_valid), 32'd0);
    repeat (3) tick("s1_empty");
    check("s1_pend_empty", 32'(irq_valid), 32'd0);

    // Simultaneous requests on all buses
    req_a = 9'h100; req_b = 9'h020; req_c = 9'h001;
    tick("s2_req");
    req_a = '0; req_b = '0; req_c = '0;
    tick("s2_g0");
    check("s2_g0_bus", 32'(irq_bus), 32'h1);
    check("s2_g0_chan", 32'(irq_chan), 32'd8);
    do_ack("s2_a0");
    check("s2_gap0", 32'(irq_valid), 32'd0);
    tick("s2_g1");
    check("s2_g1_bus", 32'(irq_bus), 32'h2);
    check("s2_g1_chan", 32'(irq_chan), 32'd5);
    do_ack("s2_a1");
    check("s2_gap1", 32'(irq_valid), 32'd0);
    tick("s2_g2");
    check("s2_g2_bus", 32'(irq_bus), 32'h4);
    check("s2_g2_chan", 32'(irq_chan), 32'd0);
    do_ack("s2_a2");

    // Disabled channel stays pending, granted once enabled
    en = 9'h1FB;
    req_a = 9'h004;
    tick("s3_req");
    req_a = '0;
    repeat (100) tick("s3_hold");
    check("s3_nogrant", 32'(irq_valid), 32'd0);
    en = '1;
    for (int i = 0; i < 2; i++) if (!irq_valid) tick("s3_en");
    check("s3_grant", 32'(irq_valid), 32'd1);
    check("s3_chan", 32'(irq_chan), 32'd2);
    do_ack("s3_ack");

    // Timeout with no ack
    req_b = 9'h002;
    tick("s4_req");
    req_b = '0;
    tick("s4_grant");
    check("s4_bus", 32'(irq_bus), 32'h2);
    check("s4_chan", 32'(irq_chan), 32'd1);
    repeat (3) tick("s4_wait");
    check("s4_still", 32'(irq_valid), 32'd1);
    tick("s4_tmo");
    check("s4_dropped", 32'(irq_valid), 32'd0);
    check("s4_err", 32'(err_timeout), 32'd1);
    repeat (3) tick("s4_after");
    check("s4_pend_clr", 32'(irq_valid), 32'd0);
    err_clr = 1'b1;
    tick("s4_clr");
    err_clr = 1'b0;
    check("s4_err_clr", 32'(err_timeout), 32'd0);

    // No preemption; re-request on ack cycle survives
    req_c = 9'h080;
    tick("s5_req");
    req_c = '0;
    tick("s5_grant");
    check("s5_g_bus", 32'(irq_bus), 32'h4);
    req_a = 9'h001;
    tick("s5_hi");
    req_a = '0;
    repeat (2) tick("s5_hold");
    check("s5_hold_bus", 32'(irq_bus), 32'h4);
    check("s5_hold_chan", 32'(irq_chan), 32'd7);
    req_c = 9'h080;
    do_ack("s5_ack");
    req_c = '0;
    tick("s5_g1");
    check("s5_g1_bus", 32'(irq_bus), 32'h1);
    check("s5_g1_chan", 32'(irq_chan), 32'd0);
    do_ack("s5_a1");
    tick("s5_g2");
    check("s5_g2_bus", 32'(irq_bus), 32'h4);
    check("s5_g2_chan", 32'(irq_chan), 32'd7);
    do_ack("s5_a2");

    // Reset in WAIT_ACK one cycle before timeout
    req_b = 9'h010;
    tick("s6_req");
    req_b = '0;
    tick("s6_grant");
    check("s6_valid", 32'(irq_valid), 32'd1);
    repeat (3) tick("s6_wait");
    rst = 1'b1;
    req_a = '1;
    tick("s6_rst");
    rst = 1'b0;
    req_a = '0;
    check("s6_valid0", 32'(irq_valid), 32'd0);
    check("s6_bus0", 32'(irq_bus), 32'd0);
    check("s6_chan0", 32'(irq_chan), 32'd0);
    check("s6_err0", 32'(err_timeout), 32'd0);
    repeat (5) tick("s6_idle");
    check("s6_nogrant", 32'(irq_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      ack     = ($urandom_range(0, 9) < 3);
      err_clr = ($urandom_range(0, 9) == 0);
      en      = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
      req_a   = NCH'($urandom & $urandom & $urandom);
      req_b   = NCH'($urandom & $urandom & $urandom);
      req_c   = NCH'($urandom & $urandom & $urandom);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_scheduler.md
IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 Parameter: NCH, 9, channels per bus; three buses A, B, C give 27 requesters.
REQ-002 Parameter: TIMEOUT, 255, maximum number of WAIT_ACK cycles before the grant is abandoned; legal range 1..65535.
REQ-003 Port: blif_clk_net  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: blif_reset_net  input  1  reset, synchronous, active-high.
REQ-005 Port: req_a  input  NCH  bus A request lines, level-sensitive.
REQ-006 Port: req_b  input  NCH  bus B request lines, level-sensitive.
REQ-007 Port: req_c  input  NCH  bus C request lines, level-sensitive.
REQ-008 Port: en  input  NCH  per-channel enable; en[i] gates channel i on all three buses.
REQ-009 Port: ack  input  1  acknowledge of the current grant.
REQ-010 Port: err_clr  input  1  clears err_timeout.
REQ-011 Port: irq_valid  output  1  a grant is presented.
REQ-012 Port: irq_bus  output  3  one-hot bus of the grant: bit0 = A, bit1 = B, bit2 = C.
REQ-013 Port: irq_chan  output  4  binary channel index of the grant, 0..NCH-1.
REQ-014 Port: err_timeout  output  1  sticky flag: a grant timed out.

Function
REQ-015 Pending register pend[27]: at every edge, pend[k] becomes 1 if req[k]=1; otherwise it holds, except that it clears when its grant is retired.
REQ-016 Retirement is by ack or by timeout. If req[k] and retirement of k occur in the same cycle, the set wins and pend[k] stays 1.
REQ-017 Eligible set = pend & {en,en,en}. Disabled pending bits are kept, never granted, and never cleared by en.
REQ-018 Priority (combinational resolver) is fixed:
- bus A over bus B over bus C;
- within a bus, lower channel index wins.
REQ-019 FSM states are IDLE and WAIT_ACK.
REQ-020 IDLE -> WAIT_ACK when the eligible set is non-empty. At that edge the winner is latched into irq_bus/irq_chan, irq_valid is set to 1, and the timeout counter is loaded with 0.
REQ-021 In WAIT_ACK, irq_bus and irq_chan are frozen; later higher-priority requests do not preempt the grant.
REQ-022 WAIT_ACK with ack=1: the granted pend bit clears (subject to REQ-016), irq_valid goes to 0, and the FSM returns to IDLE at that edge.
REQ-023 WAIT_ACK with ack=0: the counter increments each cycle. When the counter equals TIMEOUT-1 and ack=0, the grant retires as for ack, and err_timeout is set to 1.
REQ-024 ack=1 on the same cycle the counter reaches TIMEOUT-1 counts as ack, and err_timeout is not set.
REQ-025 ack is ignored in IDLE.
REQ-026 Minimum gap between consecutive grants is one IDLE cycle.
REQ-027 Latency: a req sampled at edge k sets pend at k; irq_valid is 1 after edge k+1 when the FSM was idle and the request is the highest eligible.
REQ-028 err_timeout clears on an err_clr edge. If err_clr and a new timeout occur in the same cycle, the set wins.
REQ-029 Counter width is 16 bits and never wraps in use.
REQ-030 All outputs are registered.

Reset
REQ-031 On blif_reset_net=1 at an edge:
- FSM goes to IDLE;
- pend = 0 and counter = 0;
- irq_valid = 0, irq_bus = 3'b000, irq_chan = 4'h0, err_timeout = 0.
REQ-032 Reset asserted mid-WAIT_ACK abandons the grant without setting err_timeout. Requests are ignored during reset cycles.

Structure
REQ-033 A shared package holds:
- bus one-hot constants BUS_A/BUS_B/BUS_C;
- the FSM state enum;
- channel and bus widths.
REQ-034 One sub-module, irq_prio_resolver, is purely combinational: 27 eligible bits in, found/bus/chan out. The top holds pend, the FSM and the counter.

Verification
REQ-035 Reset, then req_a[3]=1 for 1 cycle with en=9'h1FF:
- irq_valid=1, irq_bus=001, irq_chan=3 two edges later;
- ack -> irq_valid=0, pend empty.
REQ-036 req_c[0], req_b[5] and req_a[8] pulsed together, all enabled:
- grants in order A/8, B/5, C/0, one per ack;
- each grant separated by one IDLE cycle.
REQ-037 req_a[2] with en[2]=0: no grant for 100 cycles. Then en[2]=1 -> grant A/2 within 2 cycles.
REQ-038 TIMEOUT=4, req_b[1], ack never asserted:
- irq_valid low after 4 WAIT_ACK cycles, err_timeout=1, pend[B1]=0;
- err_clr -> err_timeout=0.
REQ-039 Grant of C/7; req_a[0] arrives during WAIT_ACK, and req_c[7] is reasserted on the ack cycle:
- grant stays C/7 until ack;
- next grant is A/0, then C/7 again.
REQ-040 blif_reset_net pulsed during WAIT_ACK of B/4: all outputs return to reset values, err_timeout=0, and no grant follows without a new request.
